// File: rtl/wb_gpio_debounce_pkg.sv
// Shared constants for the Wishbone GPIO/debounce block.
// Offsets are byte addresses; only bits [4:2] are decoded.
package wb_gpio_pkg;

  localparam logic [4:0] REG_IN       = 5'h00;
  localparam logic [4:0] REG_OUT      = 5'h04;
  localparam logic [4:0] REG_IRQ_EN   = 5'h08;
  localparam logic [4:0] REG_IRQ_PEND = 5'h0C;
  localparam logic [4:0] REG_EDGE     = 5'h10;

  localparam int CNT_W = 4;

  // Expands Wishbone byte-lane enables into a 32-bit write mask.
  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_gpio_debounce_if.sv
// Wishbone classic slave bus as seen by the GPIO block.
interface wb_gpio_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;

  modport master (output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
                  input  wb_dat_o, wb_ack_o);
  modport slave  (input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
                  output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/wb_gpio_debounce_bit.sv
// One input lane: 2-flop synchroniser, stable counter and debounced value.
// rise/fall pulse in the cycle whose clock edge updates the debounced flop.
module gpio_debounce_bit
  import wb_gpio_pkg::*;
#(
  parameter logic RST_VAL      = 1'b0,
  parameter int   STABLE_TICKS = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (tick) begin
      if (sync2_q == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(STABLE_TICKS - 1)) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      db_q    <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = db_q;
  assign rise = db_d & ~db_q;
  assign fall = ~db_d & db_q;

endmodule

// File: rtl/wb_gpio_debounce.sv
// Wishbone GPIO slave: debounced inputs with edge interrupts, plus an output register.
// Write side effects commit on the edge that raises ack; read data is registered into the ack cycle.
module wb_gpio_debounce
  import wb_gpio_pkg::*;
#(
  parameter int clk_freq     = 50000000,
  parameter int tick_hz      = 1000,
  parameter int stable_ticks = 8,
  parameter int in_width     = 14,
  parameter int out_width    = 18,
  parameter logic [in_width-1:0] in_reset_val = 14'h3C00
) (
  input  logic                 clk,
  input  logic                 reset_n,
  wb_gpio_if.slave             wb,
  input  logic [in_width-1:0]  gpio_in,
  output logic [out_width-1:0] gpio_out,
  output logic                 intr
);

  localparam int TERM = clk_freq / tick_hz - 1;
  localparam int PW   = (TERM > 0) ? $clog2(TERM + 1) : 1;

  logic [PW-1:0]        presc_q, presc_d;
  logic                 tick;
  logic [in_width-1:0]  db, rise, fall, evt, clr;
  logic [out_width-1:0] out_q, out_d;
  logic [in_width-1:0]  irq_en_q, irq_en_d;
  logic [in_width-1:0]  pend_q, pend_d;
  logic [in_width-1:0]  edge_q, edge_d;
  logic                 intr_q, intr_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d, rdata, wmask;
  logic                 acc, wr;
  logic [2:0]           idx;

  // Free-running prescaler; the terminal cycle is the tick.
  always_comb begin
    tick    = (presc_q == PW'(TERM));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  for (genvar i = 0; i < in_width; i++) begin : g_lane
    gpio_debounce_bit #(
      .RST_VAL      (in_reset_val[i]),
      .STABLE_TICKS (stable_ticks)
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .din     (gpio_in[i]),
      .dout    (db[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  always_comb begin
    acc   = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
    wr    = acc & wb.wb_we_i;
    idx   = wb.wb_adr_i[4:2];
    wmask = sel_mask(wb.wb_sel_i);
    ack_d = acc;

    out_d    = out_q;
    irq_en_d = irq_en_q;
    edge_d   = edge_q;
    clr      = '0;
    if (wr) begin
      if (idx == REG_OUT[4:2])
        out_d = (out_q & ~wmask[out_width-1:0]) | (wb.wb_dat_i[out_width-1:0] & wmask[out_width-1:0]);
      if (idx == REG_IRQ_EN[4:2])
        irq_en_d = (irq_en_q & ~wmask[in_width-1:0]) | (wb.wb_dat_i[in_width-1:0] & wmask[in_width-1:0]);
      if (idx == REG_EDGE[4:2])
        edge_d = (edge_q & ~wmask[in_width-1:0]) | (wb.wb_dat_i[in_width-1:0] & wmask[in_width-1:0]);
      if (idx == REG_IRQ_PEND[4:2])
        clr = wb.wb_dat_i[in_width-1:0] & wmask[in_width-1:0];
    end

    // Set is OR'd in after the clear so a coincident event survives W1C.
    evt    = (edge_q & rise) | (~edge_q & fall);
    pend_d = (pend_q & ~clr) | evt;
    intr_d = |(pend_q & irq_en_q);

    rdata = '0;
    case (idx)
      REG_IN[4:2]:       rdata[in_width-1:0]  = db;
      REG_OUT[4:2]:      rdata[out_width-1:0] = out_q;
      REG_IRQ_EN[4:2]:   rdata[in_width-1:0]  = irq_en_q;
      REG_IRQ_PEND[4:2]: rdata[in_width-1:0]  = pend_q;
      REG_EDGE[4:2]:     rdata[in_width-1:0]  = edge_q;
      default:           rdata = '0;
    endcase
    dat_d = (acc && !wb.wb_we_i) ? rdata : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q  <= '0;
      out_q    <= '0;
      irq_en_q <= '0;
      pend_q   <= '0;
      edge_q   <= '0;
      intr_q   <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      presc_q  <= presc_d;
      out_q    <= out_d;
      irq_en_q <= irq_en_d;
      pend_q   <= pend_d;
      edge_q   <= edge_d;
      intr_q   <= intr_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign gpio_out    = out_q;
  assign intr        = intr_q;

  logic unused_bits;
  assign unused_bits = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0], wb.wb_dat_i, wmask};

endmodule

// File: tb/tb_wb_gpio_debounce.sv
// Randomised bench for wb_gpio_debounce against a tick-level reference model.
module tb_wb_gpio_debounce;
  localparam int IW = 4, OW = 18, ST = 3, TERM = 9;
  localparam logic [IW-1:0] RST = 4'b1000;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic [IW-1:0] gpio_in = RST;
  logic [OW-1:0] gpio_out;
  logic          intr;

  wb_gpio_if wb();

  wb_gpio_debounce #(
    .clk_freq(1000), .tick_hz(100), .stable_ticks(ST),
    .in_width(IW), .out_width(OW), .in_reset_val(RST)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wb(wb),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .intr(intr)
  );

  always #5 clk = ~clk;

  int vec = 0, miss = 0;

  // Software-visible register shadows, updated by the bus task after commit.
  logic [IW-1:0] m_en = '0, m_edge = '0, bus_clr = '0;
  logic [OW-1:0] m_out = '0;

  // Reference model: samples seen two clocks late, one decision per tick.
  int            m_ph;
  logic [IW-1:0] m_s1, m_s2, m_db, m_ndb, m_pend, m_set;
  logic          m_intr, m_tick;
  int            m_cnt[IW], m_ncnt[IW];

  always_comb begin
    m_tick = (m_ph == TERM);
    m_ndb  = m_db;
    for (int i = 0; i < IW; i++) begin
      m_ncnt[i] = m_cnt[i];
      if (m_tick) begin
        if (m_s2[i] == m_db[i]) m_ncnt[i] = 0;
        else if (m_cnt[i] + 1 == ST) begin m_ndb[i] = m_s2[i]; m_ncnt[i] = 0; end
        else m_ncnt[i] = m_cnt[i] + 1;
      end
    end
    m_set = (m_edge & m_ndb & ~m_db) | (~m_edge & ~m_ndb & m_db);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph <= 0; m_s1 <= RST; m_s2 <= RST; m_db <= RST;
      m_pend <= '0; m_intr <= 1'b0;
      for (int i = 0; i < IW; i++) m_cnt[i] <= 0;
    end else begin
      m_ph   <= m_tick ? 0 : m_ph + 1;
      m_s1   <= gpio_in;
      m_s2   <= m_s1;
      m_db   <= m_ndb;
      m_cnt  <= m_ncnt;
      m_pend <= (m_pend & ~bus_clr) | m_set;
      m_intr <= |(m_pend & m_en);
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[4:2])
      3'd0: return {28'd0, m_db};
      3'd1: return {14'd0, m_out};
      3'd2: return {28'd0, m_en};
      3'd3: return {28'd0, m_pend};
      3'd4: return {28'd0, m_edge};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Must be entered at a negedge; returns DUT data and the model's expectation.
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rd, output logic [31:0] exp);
    logic [31:0] mk;
    mk = lanes(sel);
    wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = adr;  wb.wb_dat_i = dat;  wb.wb_sel_i = sel;
    exp = model_read(adr);
    if (we && adr[4:2] == 3'd3) bus_clr = dat[IW-1:0] & mk[IW-1:0];
    vec++;
    if (wb.wb_ack_o !== 1'b0) begin miss++; $display("FAIL ack_early: got %b exp 0", wb.wb_ack_o); end
    @(posedge clk); #1;
    bus_clr = '0;
    vec++;
    if (wb.wb_ack_o !== 1'b1) begin miss++; $display("FAIL ack_latency adr %h: got %b exp 1", adr, wb.wb_ack_o); end
    rd = wb.wb_dat_o;
    if (we) begin
      case (adr[4:2])
        3'd1: m_out  = (m_out & ~mk[OW-1:0]) | (dat[OW-1:0] & mk[OW-1:0]);
        3'd2: m_en   = (m_en & ~mk[IW-1:0]) | (dat[IW-1:0] & mk[IW-1:0]);
        3'd4: m_edge = (m_edge & ~mk[IW-1:0]) | (dat[IW-1:0] & mk[IW-1:0]);
        default: ;
      endcase
      exp = 32'd0;
    end
    @(negedge clk);
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd, exp;
    @(negedge clk); bus(1'b1, adr, dat, sel, rd, exp);
    vec++;
    if (rd !== 32'd0) begin miss++; $display("FAIL wr_dat_o adr %h: got %h exp 0", adr, rd); end
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] adr);
    logic [31:0] rd, exp;
    @(negedge clk); bus(1'b0, adr, 32'd0, 4'hF, rd, exp);
    vec++;
    if (rd !== exp) begin miss++; $display("FAIL %s adr %h: got %h exp %h", nm, adr, rd, exp); end
  endtask

  task automatic test_reset();
    vec++;
    if ({gpio_out, intr, wb.wb_ack_o} !== '0 || wb.wb_dat_o !== 32'd0) begin
      miss++; $display("FAIL reset_outs: got out %h intr %b ack %b dat %h exp 0", gpio_out, intr, wb.wb_ack_o, wb.wb_dat_o);
    end
    rd_chk("reset_in", 32'h0);
    vec++;
    if (m_db !== 4'h8) begin miss++; $display("FAIL reset_in_const: got %h exp 8", m_db); end
  endtask

  task automatic test_regs();
    logic [31:0] a;
    for (int k = 0; k < 6; k++) begin
      a = (k % 3 == 0) ? 32'h04 : (k % 3 == 1) ? 32'h08 : 32'h10;
      wr(a, $urandom, 4'($urandom_range(0, 15)));
      rd_chk("rand_reg", a);
    end
    wr(32'h08, 32'h0, 4'hF);
    wr(32'h10, 32'h0, 4'hF);
    wr(32'h04, 32'h0, 4'hF);
    wr(32'h04, 32'h0003FFFF, 4'b0011);
    rd_chk("out_sel", 32'h04);
    vec++;
    if (gpio_out !== 18'h0FFFF) begin miss++; $display("FAIL gpio_out: got %h exp 0FFFF", gpio_out); end
    wr(32'h14, 32'hFFFFFFFF, 4'hF);
    rd_chk("hole_14", 32'h14);
    rd_chk("hole_1c", 32'h1C);
    rd_chk("out_kept", 32'h04);
  endtask

  task automatic test_debounce();
    @(negedge clk); gpio_in[0] = 1'b1;
    repeat (11) @(negedge clk);
    rd_chk("in_early", 32'h0);
    vec++;
    if (m_db[0] !== 1'b0) begin miss++; $display("FAIL in0_early_model: got %b exp 0", m_db[0]); end
    repeat (35) @(negedge clk);
    rd_chk("in_settled", 32'h0);
    vec++;
    if (m_db[0] !== 1'b1) begin miss++; $display("FAIL in0_late_model: got %b exp 1", m_db[0]); end
    gpio_in[1] = 1'b1;
    repeat (20) @(negedge clk);
    gpio_in[1] = 1'b0;
    repeat (40) @(negedge clk);
    rd_chk("glitch", 32'h0);
    vec++;
    if (m_db[1] !== 1'b0) begin miss++; $display("FAIL glitch_model: got %b exp 0", m_db[1]); end
    for (int k = 0; k < 8; k++) begin
      gpio_in = 4'($urandom);
      repeat ($urandom_range(5, 45)) @(negedge clk);
      rd_chk("rand_in", 32'h0);
      vec++;
      if (intr !== m_intr) begin miss++; $display("FAIL rand_intr: got %b exp %b", intr, m_intr); end
    end
  endtask

  task automatic test_irq_rise();
    int err = 0;
    bit seen = 0;
    @(negedge clk); gpio_in = RST;
    repeat (45) @(negedge clk);
    wr(32'h10, 32'h1, 4'hF);
    wr(32'h08, 32'h1, 4'hF);
    wr(32'h0C, 32'hF, 4'hF);
    gpio_in[0] = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (intr !== m_intr) err++;
      seen = m_pend[0];
    end
    vec++;
    if (!seen || err != 0) begin miss++; $display("FAIL rise_pend: seen %0d intr_err %0d exp seen 1 err 0", seen, err); end
    vec++;
    if (intr !== 1'b0) begin miss++; $display("FAIL intr_lag: got %b exp 0", intr); end
    @(negedge clk);
    vec++;
    if (intr !== 1'b1) begin miss++; $display("FAIL intr_rise: got %b exp 1", intr); end
    rd_chk("pend_rise", 32'h0C);
    wr(32'h0C, 32'h1, 4'hF);
    vec++;
    if (intr !== 1'b1) begin miss++; $display("FAIL intr_hold: got %b exp 1", intr); end
    @(negedge clk);
    vec++;
    if (intr !== 1'b0 || m_pend !== 4'h0) begin
      miss++; $display("FAIL intr_clear: got intr %b pend %h exp 0 0", intr, m_pend);
    end
    rd_chk("pend_clr", 32'h0C);
  endtask

  task automatic test_set_wins();
    logic [31:0] rd, exp;
    bit seen = 0;
    wr(32'h10, 32'h0, 4'hF);
    wr(32'h08, 32'h8, 4'hF);
    wr(32'h0C, 32'hF, 4'hF);
    gpio_in[3] = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin @(negedge clk); seen = m_pend[3]; end
    @(negedge clk);
    vec++;
    if (!seen || intr !== 1'b1) begin miss++; $display("FAIL fall_irq: seen %0d intr %b exp 1 1", seen, intr); end
    wr(32'h0C, 32'h8, 4'hF);
    gpio_in[3] = 1'b1;
    repeat (50) @(negedge clk);
    gpio_in[3] = 1'b0;
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin @(negedge clk); seen = m_set[3]; end
    vec++;
    if (!seen) begin miss++; $display("FAIL set_wins_wait: got timeout exp event"); end
    bus(1'b1, 32'h0C, 32'h8, 4'hF, rd, exp);
    rd_chk("set_wins", 32'h0C);
    vec++;
    if (m_pend[3] !== 1'b1) begin miss++; $display("FAIL set_wins_model: got %b exp 1", m_pend[3]); end
    vec++;
    if (intr !== 1'b1) begin miss++; $display("FAIL set_wins_intr: got %b exp 1", intr); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ack_seq;
    logic [31:0] e;
    int derr = 0;
    @(negedge clk);
    wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = 32'h0; wb.wb_sel_i = 4'hF;
    for (int c = 0; c < 4; c++) begin
      e = model_read(32'h0);
      @(posedge clk); #1;
      ack_seq[3-c] = wb.wb_ack_o;
      if (wb.wb_dat_o !== (wb.wb_ack_o ? e : 32'd0)) derr++;
      @(negedge clk);
    end
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0;
    vec++;
    if (ack_seq !== 4'b1010) begin miss++; $display("FAIL b2b_ack: got %b exp 1010", ack_seq); end
    vec++;
    if (derr != 0) begin miss++; $display("FAIL b2b_data: got %0d bad cycles exp 0", derr); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = 1'b0; wb.wb_adr_i = 32'h04;
    #2 reset_n = 1'b0;
    #1;
    vec++;
    if ({gpio_out, intr, wb.wb_ack_o} !== '0 || wb.wb_dat_o !== 32'd0) begin
      miss++; $display("FAIL async_reset: got out %h intr %b ack %b dat %h exp 0", gpio_out, intr, wb.wb_ack_o, wb.wb_dat_o);
    end
    @(posedge clk); #1;
    vec++;
    if (wb.wb_ack_o !== 1'b0) begin miss++; $display("FAIL reset_no_ack: got %b exp 0", wb.wb_ack_o); end
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0;
    m_out = '0; m_en = '0; m_edge = '0;
    gpio_in = RST;
    #6 reset_n = 1'b1;
    rd_chk("post_reset_in", 32'h0);
    rd_chk("post_reset_out", 32'h04);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0;
    #22 reset_n = 1'b1;
    test_reset();
    test_regs();
    test_debounce();
    test_irq_rise();
    test_set_wins();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
